// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the CPU run-mode sequencer.
// Mode codes match the display/IO path; the FSM state code is the mode code.
package run_ctrl_pkg;

    localparam logic [3:0] MODE_LOAD   = 4'd2;
    localparam logic [3:0] MODE_IDLE   = 4'd4;
    localparam logic [3:0] MODE_RUN    = 4'd5;
    localparam logic [3:0] MODE_IOWAIT = 4'd6;
    localparam logic [3:0] MODE_STEP   = 4'd7;

    // Default length of the CPU reset pulse, in clk_i cycles (1..15)
    localparam int unsigned RST_CYCLES_DEF = 4;

    typedef enum logic [3:0] {
        ST_LOAD   = MODE_LOAD,
        ST_IDLE   = MODE_IDLE,
        ST_RUN    = MODE_RUN,
        ST_IOWAIT = MODE_IOWAIT,
        ST_STEP   = MODE_STEP
    } state_e;

    // States in which the CPU is allowed to execute
    function automatic logic is_exec_state(input state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/run_ctrl_fsm_sat_counter.sv
// Enable/clear saturating up-counter used for the executed-cycle count.
// Clear wins over increment; the count sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         en_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    // Count register: clear, saturating increment, or hold
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= {W{1'b0}};
        end else if (clr_i) begin
            cnt_q <= {W{1'b0}};
        end else if (en_i && !(&cnt_q)) begin
            cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/run_ctrl_fsm.sv
// CPU run-mode sequencer: arbitrates load/start/halt/IO-wait requests into one
// mode, drives CPU clock-enable and reset, and counts executed cycles.
// Optional single-step support is built when RUN_CTRL_SINGLE_STEP_EN is defined.
module run_ctrl_fsm
    import run_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned RST_CYCLES = RST_CYCLES_DEF
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_req_i,
    input  logic             load_done_i,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             halt_i,
    input  logic             io_req_i,
    input  logic             io_ack_i,
    input  logic             cnt_clr_i,
    output logic [3:0]       mode_o,
    output logic             cpu_ce_o,
    output logic             cpu_rst_n_o,
    output logic             load_err_o,
    output logic [CNT_W-1:0] cycle_cnt_o
);

    localparam logic [3:0] RST_LOAD = 4'(RST_CYCLES);

    state_e     state_q, state_d;
    logic [3:0] rcnt_q, rcnt_d;
    logic       ce_q, ce_d;
    logic       rstn_q, rstn_d;
    logic       err_q, err_d;
    logic       load_ok_s;

`ifndef RUN_CTRL_SINGLE_STEP_EN
    // The step button has no effect in this build
    logic step_unused_s;
    assign step_unused_s = step_i;
`endif

    // Next-state, reset-pulse countdown and sticky load-error decision
    always_comb begin
        state_d   = state_q;
        err_d     = err_q;
        load_ok_s = 1'b0;
        if (rcnt_q != 4'd0) begin
            rcnt_d = rcnt_q - 4'd1;
        end else begin
            rcnt_d = 4'd0;
        end

        case (state_q)
            ST_IDLE: begin
                if (load_req_i) begin
                    state_d = ST_LOAD;
                end else if (start_i) begin
                    state_d = ST_RUN;
`ifdef RUN_CTRL_SINGLE_STEP_EN
                end else if (step_i) begin
                    state_d = ST_STEP;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_done_i) begin
                    // Fresh program: pulse CPU reset and restart the count
                    state_d   = ST_IDLE;
                    rcnt_d    = RST_LOAD;
                    load_ok_s = 1'b1;
                end else if (!load_req_i) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (load_req_i) begin
                    state_d = ST_LOAD;
                end else if (io_req_i) begin
                    state_d = ST_IOWAIT;
                end else if (halt_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_IOWAIT: begin
                // A dropped io_req_i without ack keeps waiting for the user
                if (load_req_i) begin
                    state_d = ST_LOAD;
                end else if (io_ack_i) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IOWAIT;
                end
            end
`ifdef RUN_CTRL_SINGLE_STEP_EN
            ST_STEP: begin
                if (load_req_i) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new load attempt forgets the previous failure
        if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
            err_d = 1'b0;
        end else begin
            err_d = err_d;
        end

        rstn_d = (rcnt_d == 4'd0);
        ce_d   = is_exec_state(state_d) && rstn_d;
    end

    // State and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            rcnt_q  <= RST_LOAD;
            ce_q    <= 1'b0;
            rstn_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            ce_q    <= ce_d;
            rstn_q  <= rstn_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (ce_q),
        .clr_i   (cnt_clr_i | load_ok_s),
        .cnt_o   (cycle_cnt_o)
    );

    assign mode_o      = state_q;
    assign cpu_ce_o    = ce_q;
    assign cpu_rst_n_o = rstn_q;
    assign load_err_o  = err_q;

endmodule

// File: tb/tb_run_ctrl_fsm.sv
// Self-checking bench for run_ctrl_fsm: directed scenarios followed by random
// stimulus, all compared against a mode-level reference model.
module tb_run_ctrl_fsm;

    localparam int CNT_W = 6;
    localparam int RSTC  = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef RUN_CTRL_SINGLE_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load_req = 1'b0, load_done = 1'b0, start = 1'b0, step = 1'b0;
    logic             halt = 1'b0, io_req = 1'b0, io_ack = 1'b0, cnt_clr = 1'b0;
    logic [3:0]       mode;
    logic             ce, cpu_rst_n, load_err;
    logic [CNT_W-1:0] cnt;

    run_ctrl_fsm #(.CNT_W(CNT_W), .RST_CYCLES(RSTC)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .load_req_i  (load_req),
        .load_done_i (load_done),
        .start_i     (start),
        .step_i      (step),
        .halt_i      (halt),
        .io_req_i    (io_req),
        .io_ack_i    (io_ack),
        .cnt_clr_i   (cnt_clr),
        .mode_o      (mode),
        .cpu_ce_o    (ce),
        .cpu_rst_n_o (cpu_rst_n),
        .load_err_o  (load_err),
        .cycle_cnt_o (cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: current mode code, remaining reset cycles, count, flags
    int m_mode, m_rc, m_cnt;
    bit m_err, m_ce;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".mode"}, 64'(mode), 64'(m_mode));
        check_val({tag, ".ce"}, 64'(ce), 64'(m_ce));
        check_val({tag, ".rst_n"}, 64'(cpu_rst_n), 64'(m_rc == 0));
        check_val({tag, ".err"}, 64'(load_err), 64'(m_err));
        check_val({tag, ".cnt"}, 64'(cnt), 64'(m_cnt));
    endtask

    task automatic model_reset();
        m_mode = 4; m_rc = RSTC; m_cnt = 0; m_err = 1'b0; m_ce = 1'b0;
    endtask

    // One clock edge of the specified behaviour, using the inputs now applied
    task automatic model_step();
        int nm;
        bit done_ok;
        done_ok = (m_mode == 2) && load_done;
        case (m_mode)
            4: nm = load_req ? 2 : start ? 5 : (STEP_EN && step) ? 7 : 4;
            2: nm = (load_done || !load_req) ? 4 : 2;
            5: nm = load_req ? 2 : io_req ? 6 : halt ? 4 : 5;
            6: nm = load_req ? 2 : io_ack ? 5 : 6;
            7: nm = load_req ? 2 : 4;
            default: nm = 4;
        endcase
        if (cnt_clr || done_ok) m_cnt = 0;
        else if (m_ce && m_cnt < CMAX) m_cnt = m_cnt + 1;
        if (m_mode == 2 && !load_done && !load_req) m_err = 1'b1;
        else if (nm == 2 && m_mode != 2) m_err = 1'b0;
        if (done_ok) m_rc = RSTC;
        else if (m_rc > 0) m_rc = m_rc - 1;
        m_ce = (nm == 5 || nm == 7) && (m_rc == 0);
        m_mode = nm;
    endtask

    // Apply one clock: model follows the edge, outputs checked on the falling edge
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
        load_done = 1'b0; start = 1'b0; step = 1'b0; halt = 1'b0;
        io_ack = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    // Asynchronous reset in the middle of a cycle, released on a falling edge
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all(tag);
        @(negedge clk);
        check_all(tag);
        rst_n = 1'b1;
    endtask

    int snap;

    initial begin
        // Reset and CPU reset pulse length
        @(negedge clk);
        model_reset();
        check_all("reset");
        check_val("reset.mode_const", 64'(mode), 64'd4);
        rst_n = 1'b1;
        for (int i = 0; i < RSTC; i++) begin
            tick("rel");
            check_val("rel.rst_pulse", 64'(cpu_rst_n), 64'(i == RSTC - 1));
        end

        // Start, run 10 cycles, halt
        start = 1'b1; tick("start");
        check_val("start.ce", 64'(ce), 64'd1);
        check_val("start.mode", 64'(mode), 64'd5);
        ticks(9, "run");
        halt = 1'b1; tick("halt");
        check_val("halt.mode", 64'(mode), 64'd4);
        check_val("halt.cnt", 64'(cnt), 64'd10);

        // Successful load
        load_req = 1'b1; tick("load");
        check_val("load.mode", 64'(mode), 64'd2);
        load_done = 1'b1; tick("ldone");
        load_req = 1'b0;
        check_val("ldone.cnt", 64'(cnt), 64'd0);
        for (int i = 0; i < RSTC; i++) begin
            check_val("ldone.rst_low", 64'(cpu_rst_n), 64'd0);
            tick("ldrst");
        end
        check_val("ldone.rst_high", 64'(cpu_rst_n), 64'd1);

        // Aborted load, then error cleared by the next load
        load_req = 1'b1; tick("ab1");
        load_req = 1'b0; tick("ab2");
        check_val("abort.err", 64'(load_err), 64'd1);
        load_req = 1'b1; tick("ab3");
        check_val("reload.err", 64'(load_err), 64'd0);
        load_done = 1'b1; tick("ab4");
        load_req = 1'b0; ticks(RSTC, "ab5");

        // I/O wait freezes the count; ack resumes
        start = 1'b1; ticks(4, "io0");
        io_req = 1'b1; tick("io1");
        check_val("io.mode", 64'(mode), 64'd6);
        check_val("io.ce", 64'(ce), 64'd0);
        snap = int'(cnt);
        io_req = 1'b0; ticks(3, "io2");
        check_val("io.frozen", 64'(cnt), 64'(snap));
        io_ack = 1'b1; tick("io3");
        check_val("ack.mode", 64'(mode), 64'd5);

        // Coincident requests: load wins; clear beats increment
        load_req = 1'b1; io_req = 1'b1; halt = 1'b1; tick("sim");
        check_val("sim.mode", 64'(mode), 64'd2);
        io_req = 1'b0; load_done = 1'b1; tick("sim2");
        load_req = 1'b0; ticks(RSTC, "sim3");
        start = 1'b1; ticks(3, "clr0");
        cnt_clr = 1'b1; tick("clr");
        check_val("clr.cnt", 64'(cnt), 64'd0);

        // Saturation
        ticks(CMAX + 8, "sat");
        check_val("sat.cnt", 64'(cnt), 64'(CMAX));
        halt = 1'b1; tick("sat_halt");

        // Single step (feature-dependent)
        cnt_clr = 1'b1; tick("st0");
        step = 1'b1; tick("st1");
        check_val("step.ce", 64'(ce), 64'(STEP_EN));
        tick("st2");
        check_val("step.mode", 64'(mode), 64'd4);
        check_val("step.cnt", 64'(cnt), 64'(STEP_EN));

        // Random phase with occasional mid-operation resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) load_req = ~load_req;
            if ($urandom_range(0, 9) == 0) io_req = ~io_req;
            load_done = ($urandom_range(0, 5) == 0);
            start     = ($urandom_range(0, 7) == 0);
            step      = ($urandom_range(0, 7) == 0);
            halt      = ($urandom_range(0, 11) == 0);
            io_ack    = ($urandom_range(0, 7) == 0);
            cnt_clr   = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
            else tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/run_ctrl_fsm.md
Name: run_ctrl_fsm

Overview:
- CPU run-mode sequencer in the processor clock domain.
- Arbitrates load, start, halt and I/O-wait requests from the UART loader, buttons and the CPU core into one mode.
- Drives the CPU clock-enable and CPU reset, and keeps an executed-cycle counter for the board display.
- Mode encoding is the one already used by the display/IO path: 2 = load, 4 = idle, 5 = run, 6 = I/O wait.

Parameters:
- CNT_W, 32, width of the executed-cycle counter.
- RST_CYCLES, 4, number of cycles cpu_rst_n_o is held low after reset release and after a completed program load (range 1..15).

Ports:
- clk_i  input  1  processor clock (10 MHz domain).
- rst_n_i  input  1  asynchronous active-low reset.
- load_req_i  input  1  level; UART loader is receiving a program.
- load_done_i  input  1  one-cycle pulse; loader finished successfully.
- start_i  input  1  one-cycle pulse; start/resume button, already synchronised.
- step_i  input  1  one-cycle pulse; single-step button, used only with the optional feature.
- halt_i  input  1  one-cycle pulse; CPU executed its exit/halt instruction.
- io_req_i  input  1  level; CPU is stalled on an input read.
- io_ack_i  input  1  one-cycle pulse; user confirmed the input value.
- cnt_clr_i  input  1  synchronous clear of the cycle counter.
- mode_o  output  4  current mode code.
- cpu_ce_o  output  1  CPU clock-enable.
- cpu_rst_n_o  output  1  CPU reset, active-low.
- load_err_o  output  1  sticky flag: load aborted without done.
- cycle_cnt_o  output  CNT_W  executed-cycle count.

Behaviour:
- Clock and reset (already decided): one clock, clk_i; reset rst_n_i is asynchronous and active-low.
- Reset values: state IDLE, mode_o = 4, cpu_ce_o = 0, cpu_rst_n_o = 0, load_err_o = 0, cycle_cnt_o = 0.
- Reset counter: loaded with RST_CYCLES during reset. cpu_rst_n_o stays low until the counter reaches 0, i.e. exactly RST_CYCLES clk_i edges after rst_n_i rises.
- States (state code = mode_o): IDLE (4), LOAD (2), RUN (5), IOWAIT (6), STEP (7, feature only). State is registered; mode_o and cpu_ce_o are decoded from it.
- cpu_ce_o = 1 only in RUN or STEP, and only while cpu_rst_n_o = 1. Latency: start_i in cycle N gives cpu_ce_o = 1 in cycle N+1.
- Request priority when events coincide: load_req_i > io_req_i > halt_i > start_i > step_i.
- IDLE: load_req_i -> LOAD; else start_i -> RUN; else step_i -> STEP.
- LOAD:
  - load_done_i -> IDLE, reload reset counter with RST_CYCLES, clear cycle counter.
  - load_req_i falls with no load_done_i in the same cycle -> IDLE, set load_err_o.
  - load_err_o clears on the next entry to LOAD or on reset.
- RUN: load_req_i -> LOAD (run aborted, ce drops next cycle); else io_req_i -> IOWAIT; else halt_i -> IDLE. start_i is ignored.
- IOWAIT: load_req_i -> LOAD; else io_ack_i -> RUN. If io_req_i falls without an ack, stay in IOWAIT until io_ack_i.
- STEP: ce high for exactly one cycle, then IDLE. load_req_i still has priority.
- Cycle counter: +1 on every cycle with cpu_ce_o = 1. Saturates at all-ones, no wrap. cnt_clr_i has priority over increment in the same cycle.
- Reset mid-operation: asynchronous return to reset values from any state, including mid-LOAD and mid-reset-pulse.

Optional Feature:
- Macro: RUN_CTRL_SINGLE_STEP_EN.
- Defined: STEP state exists and step_i is honoured from IDLE.
- Undefined: step_i is ignored (port kept), STEP state is not synthesised, code 7 is never produced.

Decomposition:
- Shared package run_ctrl_pkg:
  - mode constants MODE_LOAD = 4'd2, MODE_IDLE = 4'd4, MODE_RUN = 4'd5, MODE_IOWAIT = 4'd6, MODE_STEP = 4'd7.
  - state typedef.
  - default RST_CYCLES.
- Sub-module: sat_counter (CNT_W-bit enable/clear saturating counter) for cycle_cnt_o.

Test Plan:
- Reset: release rst_n_i with RST_CYCLES = 4 -> cpu_rst_n_o rises exactly 4 edges later; mode_o = 4, cpu_ce_o = 0 throughout.
- Start and halt: start_i pulse -> mode 5, ce = 1 the next cycle; 10 cycles later halt_i -> mode 4; cycle_cnt_o = 10.
- Load: load_req_i high, then load_done_i -> mode 2 then 4; cpu_rst_n_o low 4 cycles; counter 0. Second load with load_req_i dropped and no done -> load_err_o = 1.
- I/O wait: io_req_i during RUN -> mode 6, ce = 0, counter frozen; io_ack_i -> mode 5 the next cycle.
- Simultaneous: load_req_i, io_req_i and halt_i in the same RUN cycle -> LOAD. cnt_clr_i together with increment -> counter 0. Force counter to all-ones and run -> stays all-ones.
- Feature on: step_i in IDLE -> exactly one ce cycle, counter +1, back to mode 4. Feature off: step_i -> no change.
